freelist: RTL and testbench

- Physical-register free list for the 4-wide rename stage.
- Sits directly upstream of the rename map table and supplies the new physical tags written into it.
- Circular buffer of free tags: allocation from head at rename, release at tail from commit.
- Single checkpoint of the head pointer, saved and restored in lockstep with the map table checkpoint.

---
 rtl/rename_pkg.sv | 19 +
 rtl/freelist_if.sv | 31 +++
 rtl/popcnt_prefix4.sv | 14 +
 rtl/freelist.sv | 94 +++++++++
 tb/tb_freelist.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_pkg.sv
// Shared rename-stage constants and the prefix popcount helper used by the
// free list and the rename map table.
package rename_pkg;

  localparam int RENAME_W = 4;
  localparam int TAG_W    = 6;

  // Number of set bits in mask[n-1:0]; n ranges over 0..RENAME_W.
  function automatic logic [2:0] popcnt_below(input logic [RENAME_W-1:0] mask,
                                              input int n);
    logic [2:0] c;
    c = '0;
    for (int b = 0; b < RENAME_W; b++) begin
      if (b < n && mask[b]) c = c + 3'd1;
    end
    return c;
  endfunction

endpackage

// File: rtl/freelist_if.sv
// Rename-side and commit-side signal bundle of the physical-register free list.
interface freelist_if #(parameter int WIDTH = rename_pkg::TAG_W);
  import rename_pkg::*;

  // Allocation handshake: o_ready is the ready, i_alloc_en the valid; a group
  // is granted exactly on a cycle where both are high and i_return is low.
  // o_ready is derived from registered state only, never from i_req_mask.
  logic [RENAME_W-1:0]       i_req_mask;
  logic                      i_alloc_en;
  logic [RENAME_W*WIDTH-1:0] o_tags4x;
  logic                      o_ready;
  logic [RENAME_W-1:0]       i_free_mask;
  logic [RENAME_W*WIDTH-1:0] i_free_tags4x;
  logic                      i_save_en;
  logic [RENAME_W-1:0]       i_save_mask;
  logic                      i_return;
  logic [WIDTH:0]            o_count;

  modport master (
    output i_req_mask, i_alloc_en, i_free_mask, i_free_tags4x,
           i_save_en, i_save_mask, i_return,
    input  o_tags4x, o_ready, o_count
  );

  modport slave (
    input  i_req_mask, i_alloc_en, i_free_mask, i_free_tags4x,
           i_save_en, i_save_mask, i_return,
    output o_tags4x, o_ready, o_count
  );

endinterface

// File: rtl/popcnt_prefix4.sv
// Prefix popcount of a 4-bit slot mask: pre[i] = set bits in mask[i-1:0],
// pre[4] = total.
module popcnt_prefix4
  import rename_pkg::*;
(
  input  logic [RENAME_W-1:0]      mask,
  output logic [RENAME_W:0][2:0]   pre
);

  for (genvar g = 0; g <= RENAME_W; g++) begin : g_pre
    assign pre[g] = popcnt_below(mask, g);
  end

endmodule

// File: rtl/freelist.sv
// Physical-register free list: circular buffer of free tags with one head
// checkpoint. Optional stall counter enabled by macro FREELIST_STATS_EN.
module freelist
  import rename_pkg::*;
#(
  parameter int WIDTH = TAG_W
) (
  input  logic        i_clk,
  input  logic        i_rst,
  freelist_if.slave   fl
`ifdef FREELIST_STATS_EN
  ,
  output logic [31:0] o_stall_cnt
`endif
);

  localparam int DEPTH = 1 << WIDTH;

  logic [WIDTH-1:0]         ram [DEPTH];
  logic [WIDTH:0]           head;
  logic [WIDTH:0]           tail;
  logic [WIDTH:0]           saved_head;
  logic [WIDTH:0]           count;
  logic [RENAME_W:0][2:0]   alloc_pre;
  logic [RENAME_W:0][2:0]   free_pre;
  logic [RENAME_W-1:0]      free_eff;
  logic [2:0]               save_cnt;
  logic                     alloc_fire;

  // Tag 0 is never held, so a release of tag 0 is dropped entirely.
  for (genvar g = 0; g < RENAME_W; g++) begin : g_free
    assign free_eff[g] = fl.i_free_mask[g] && (fl.i_free_tags4x[g*WIDTH +: WIDTH] != '0);
  end

  popcnt_prefix4 u_alloc_pre (.mask(fl.i_req_mask), .pre(alloc_pre));
  popcnt_prefix4 u_free_pre  (.mask(free_eff),      .pre(free_pre));

  assign count      = tail - head;
  assign fl.o_count = count;
  assign fl.o_ready = (count >= (WIDTH+1)'(4));
  assign alloc_fire = fl.i_alloc_en && fl.o_ready && !fl.i_return;
  assign save_cnt   = popcnt_below(fl.i_req_mask & fl.i_save_mask, RENAME_W);

  // Requesting slots receive consecutive entries from head, in slot order.
  for (genvar g = 0; g < RENAME_W; g++) begin : g_slot
    logic [WIDTH-1:0] idx;
    assign idx = head[WIDTH-1:0] + WIDTH'(alloc_pre[g]);
    assign fl.o_tags4x[g*WIDTH +: WIDTH] = fl.i_req_mask[g] ? ram[idx] : '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head       <= '0;
      tail       <= (WIDTH+1)'(DEPTH - 1);
      saved_head <= '0;
    end else begin
      tail <= tail + (WIDTH+1)'(free_pre[RENAME_W]);
      if (fl.i_return) begin
        head <= saved_head;
      end else if (alloc_fire) begin
        head <= head + (WIDTH+1)'(alloc_pre[RENAME_W]);
      end
      // Slots older than the branch keep their tags across a later restore.
      if (fl.i_save_en && !fl.i_return) begin
        saved_head <= head + (WIDTH+1)'(alloc_fire ? save_cnt : 3'd0);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        ram[k] <= (k == DEPTH - 1) ? '0 : WIDTH'(k + 1);
      end
    end else begin
      for (int i = 0; i < RENAME_W; i++) begin
        if (free_eff[i]) begin
          ram[tail[WIDTH-1:0] + WIDTH'(free_pre[i])] <= fl.i_free_tags4x[i*WIDTH +: WIDTH];
        end
      end
    end
  end

`ifdef FREELIST_STATS_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stall_cnt <= '0;
    end else if (fl.i_alloc_en && !fl.o_ready && !fl.i_return && (o_stall_cnt != '1)) begin
      o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_freelist.sv
// Bench for freelist: an unbounded tag-history model checked every cycle,
// plus hand-computed directed expectations.
module tb_freelist;

  localparam int W  = 6;
  localparam int NT = (1 << W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  freelist_if #(.WIDTH(W)) bus ();

`ifdef FREELIST_STATS_EN
  logic [31:0] stall_cnt;
`endif

  freelist #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .fl    (bus)
`ifdef FREELIST_STATS_EN
    ,
    .o_stall_cnt (stall_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*W-1:0] tags(input int s3, input int s2, input int s1, input int s0);
    return {W'(s3), W'(s2), W'(s1), W'(s0)};
  endfunction

  // ---------------- model ----------------
  // hist is every tag ever placed in the list, in order; the live free set is
  // hist[m_head .. hist.size()-1]. No wrap, no ring: just an index into history.
  int          hist[$];
  int          m_head;
  int          m_saved;
  logic [31:0] m_stall;
  bit          in_use[64];
  int          out_q[$];

  always @(negedge clk) begin : cmp
    int               cnt;
    int               k;
    int               sc;
    logic             rdy;
    logic             fire;
    logic [4*W-1:0]   et;
    int               t;
    if (rst) begin
      hist.delete();
      for (int i = 1; i <= NT; i++) hist.push_back(i);
      m_head  = 0;
      m_saved = 0;
      m_stall = '0;
      out_q.delete();
      for (int i = 0; i < 64; i++) in_use[i] = 1'b0;
    end else begin
      cnt = hist.size() - m_head;
      rdy = (cnt >= 4);
      check("count", bus.o_count, cnt);
      check("ready", bus.o_ready, rdy);
      if (rdy) begin
        et = '0;
        k  = 0;
        for (int i = 0; i < 4; i++) begin
          if (bus.i_req_mask[i]) begin
            et[i*W +: W] = W'(hist[m_head + k]);
            k++;
          end
        end
        check("tags", bus.o_tags4x, et);
      end
`ifdef FREELIST_STATS_EN
      check("stall", stall_cnt, m_stall);
      if (bus.i_alloc_en && !rdy && !bus.i_return && m_stall != '1) m_stall++;
`endif
      fire = bus.i_alloc_en && rdy && !bus.i_return;
      if (bus.i_save_en && !bus.i_return) begin
        sc = 0;
        if (fire)
          for (int i = 0; i < 4; i++) if (bus.i_req_mask[i] && bus.i_save_mask[i]) sc++;
        m_saved = m_head + sc;
      end
      for (int i = 0; i < 4; i++) begin
        t = int'(bus.i_free_tags4x[i*W +: W]);
        if (bus.i_free_mask[i] && t != 0) begin
          hist.push_back(t);
          in_use[t] = 1'b0;
        end
      end
      if (bus.i_return) begin
        for (int j = m_saved; j < m_head; j++) in_use[hist[j]] = 1'b0;
        for (int j = m_saved; j < m_head; j++) if (out_q.size() > 0) void'(out_q.pop_back());
        m_head = m_saved;
      end else if (fire) begin
        for (int i = 0; i < 4; i++) begin
          if (bus.i_req_mask[i]) begin
            t = int'(bus.o_tags4x[i*W +: W]);
            check("unique", {63'd0, in_use[t]}, 64'd0);
            in_use[t] = 1'b1;
            out_q.push_back(hist[m_head]);
            m_head++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] req, input logic alloc, input logic [3:0] fm,
                       input logic [4*W-1:0] ft, input logic save, input logic [3:0] sm,
                       input logic ret);
    bus.i_req_mask    = req;
    bus.i_alloc_en    = alloc;
    bus.i_free_mask   = fm;
    bus.i_free_tags4x = ft;
    bus.i_save_en     = save;
    bus.i_save_mask   = sm;
    bus.i_return      = ret;
  endtask

  task automatic idle();
    drive(4'b0, 1'b0, 4'b0, '0, 1'b0, 4'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    logic [3:0]     req_pat [6];
    logic [3:0]     free_pat[4];
    logic [3:0]     fm;
    logic [4*W-1:0] ft;
    req_pat  = '{4'b1111, 4'b0101, 4'b1011, 4'b0110, 4'b1000, 4'b1111};
    free_pat = '{4'b1111, 4'b1010, 4'b0111, 4'b0001};

    // Reset values and first group
    rst = 1'b1;
    drive(4'b1111, 1'b1, 4'b0, '0, 1'b0, 4'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", bus.o_count, 63);
    check("rst_ready", bus.o_ready, 1);
    check("rst_tags", bus.o_tags4x, tags(4, 3, 2, 1));
`ifdef FREELIST_STATS_EN
    check("rst_stall", stall_cnt, 0);
`endif
    rst = 1'b0;
    step();
    check("g2_count", bus.o_count, 59);
    check("g2_tags", bus.o_tags4x, tags(8, 7, 6, 5));

    // Sparse request mask
    do_reset();
    drive(4'b0101, 1'b1, 4'b0, '0, 1'b0, 4'b0, 1'b0);
    #1;
    check("sparse_tags", bus.o_tags4x, tags(0, 2, 0, 1));
    step();
    check("sparse_count", bus.o_count, 61);

    // Drain to 3, stall, release one
    drive(4'b0011, 1'b1, 4'b0, '0, 1'b0, 4'b0, 1'b0);
    step();
    drive(4'b1111, 1'b1, 4'b0, '0, 1'b0, 4'b0, 1'b0);
    repeat (14) step();
    check("drain_count", bus.o_count, 3);
    check("drain_ready", bus.o_ready, 0);
    repeat (2) step();
    check("stall_count", bus.o_count, 3);
`ifdef FREELIST_STATS_EN
    check("stall_cnt", stall_cnt, 2);
`endif
    drive(4'b0, 1'b0, 4'b0001, tags(0, 0, 0, 1), 1'b0, 4'b0, 1'b0);
    step();
    check("refill_count", bus.o_count, 4);
    check("refill_ready", bus.o_ready, 1);
`ifdef FREELIST_STATS_EN
    check("refill_stall", stall_cnt, 2);
`endif

    // Checkpoint and restore
    do_reset();
    drive(4'b1111, 1'b1, 4'b0, '0, 1'b1, 4'b0011, 1'b0);
    step();
    drive(4'b1111, 1'b1, 4'b0, '0, 1'b0, 4'b0, 1'b0);
    step();
    drive(4'b0, 1'b0, 4'b0, '0, 1'b0, 4'b0, 1'b1);
    step();
    drive(4'b0001, 1'b0, 4'b0, '0, 1'b0, 4'b0, 1'b0);
    #1;
    check("ret_tag", bus.o_tags4x, tags(0, 0, 0, 3));
    check("ret_count", bus.o_count, 61);

    // Restore with same-cycle alloc and free; then save+return together
    do_reset();
    drive(4'b1111, 1'b1, 4'b0, '0, 1'b0, 4'b0, 1'b0);
    repeat (2) step();
    drive(4'b1111, 1'b1, 4'b0, '0, 1'b1, 4'b0011, 1'b0);
    step();
    drive(4'b1111, 1'b1, 4'b0, '0, 1'b0, 4'b0, 1'b0);
    step();
    drive(4'b1111, 1'b1, 4'b0001, tags(0, 0, 0, 9), 1'b0, 4'b0, 1'b1);
    step();
    check("retfree_count", bus.o_count, 54);
    drive(4'b0001, 1'b0, 4'b0, '0, 1'b0, 4'b0, 1'b0);
    #1;
    check("retfree_tag", bus.o_tags4x, tags(0, 0, 0, 11));
    drive(4'b1111, 1'b1, 4'b0, '0, 1'b1, 4'b1111, 1'b1);
    step();
    drive(4'b1111, 1'b1, 4'b0, '0, 1'b0, 4'b0, 1'b0);
    step();
    drive(4'b0, 1'b0, 4'b0, '0, 1'b0, 4'b0, 1'b1);
    step();
    check("retsave_count", bus.o_count, 54);

    // Release of tag 0 is dropped, tag 1 alongside it is kept
    drive(4'b0, 1'b0, 4'b0011, tags(0, 0, 1, 0), 1'b0, 4'b0, 1'b0);
    step();
    check("zero_free_count", bus.o_count, 55);

    // Wrap-around: stream tags through alloc and in-order release
    do_reset();
    for (int c = 0; c < 150; c++) begin
      fm = 4'b0;
      ft = '0;
      if (out_q.size() >= 8) begin
        for (int i = 0; i < 4; i++) begin
          if (free_pat[c % 4][i]) begin
            fm[i]        = 1'b1;
            ft[i*W +: W] = W'(out_q.pop_front());
          end
        end
      end
      drive(req_pat[c % 6], 1'b1, fm, ft, 1'b0, 4'b0, 1'b0);
      step();
    end
    idle();
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
